// File: rtl/vpg_timing_pattern.sv
// Parametrised video timing and test-pattern generator. Pixel requests (pix_req/pix_x/pix_y) lead
// the registered DE/sync/RGB by EXT_LAT+1 cycles so an external pixel source can keep up.
module vpg_timing_pattern #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned EXT_LAT  = 1,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned CHK_LOG2 = 4
) (
    input  logic          clk_25,
    input  logic          reset_n,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    input  logic [23:0]   ext_rgb,
    output logic          pix_req,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic          vpg_de,
    output logic          vpg_hs,
    output logic          vpg_vs,
    output logic [7:0]    vpg_r,
    output logic [7:0]    vpg_g,
    output logic [7:0]    vpg_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE >> 3;

    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] BAR_LAST  = XW'(BAR_W - 1);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic        active;
        logic        hs_act;
        logic        vs_act;
        logic        ext;
        logic [23:0] rgb;
    } stage_t;

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [23:0]   solid_q, solid_d;
    logic [XW-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]    bar_idx_q, bar_idx_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [23:0]   rgb_q, rgb_d;

    logic          h_wrap;
    logic          at_origin;
    logic          active;
    logic          hs_act;
    logic          vs_act;
    logic [1:0]    mode_eff;
    logic [23:0]   solid_eff;
    logic [23:0]   bar_rgb;
    logic [23:0]   pat_rgb;
    stage_t        head;
    stage_t        tail;

    // Counter-stage decode
    assign h_wrap    = (h_q == H_LAST);
    assign at_origin = (h_q == '0) && (v_q == '0);
    assign active    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign hs_act    = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_act    = (v_q >= VS_START) && (v_q < VS_END);

    // The frame's first pixel must already use the mode being sampled this cycle.
    assign mode_eff  = at_origin ? mode : mode_q;
    assign solid_eff = at_origin ? solid_rgb : solid_q;

    always_comb begin
        h_d         = h_q + XW'(1);
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;
        if (h_wrap) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d         = '0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                v_d = v_q + YW'(1);
            end
        end
    end

    // Bar index follows h without a divider; index 8 means past the last bar (black).
    always_comb begin
        bar_cnt_d = bar_cnt_q + XW'(1);
        bar_idx_d = bar_idx_q;
        if (h_wrap) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 4'd8) begin
                bar_idx_d = bar_idx_q + 4'd1;
            end
        end
    end

    always_comb begin
        mode_d  = mode_eff;
        solid_d = solid_eff;
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx_q)
            4'd0:    bar_rgb = 24'hFFFFFF;
            4'd1:    bar_rgb = 24'hFFFF00;
            4'd2:    bar_rgb = 24'h00FFFF;
            4'd3:    bar_rgb = 24'h00FF00;
            4'd4:    bar_rgb = 24'hFF00FF;
            4'd5:    bar_rgb = 24'hFF0000;
            4'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pat_rgb = 24'h000000;
        case (mode_eff)
            2'd0:    pat_rgb = solid_eff;
            2'd1:    pat_rgb = bar_rgb;
            2'd2:    pat_rgb = (h_q[CHK_LOG2] ^ v_q[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            default: pat_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        head.active = active;
        head.hs_act = hs_act;
        head.vs_act = vs_act;
        head.ext    = (mode_eff == 2'd3);
        head.rgb    = pat_rgb;
    end

    // EXT_LAT delay stages; the output register below supplies the final cycle of latency.
    generate
        if (EXT_LAT == 0) begin : g_no_dly
            assign tail = head;
        end else begin : g_dly
            stage_t dly_q [EXT_LAT];
            stage_t dly_d [EXT_LAT];

            always_comb begin
                dly_d[0] = head;
                for (int i = 1; i < int'(EXT_LAT); i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk_25 or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(EXT_LAT); i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign tail = dly_q[EXT_LAT-1];
        end
    endgenerate

    always_comb begin
        de_d  = tail.active;
        hs_d  = tail.hs_act ? HS_POL : ~HS_POL;
        vs_d  = tail.vs_act ? VS_POL : ~VS_POL;
        rgb_d = 24'h000000;
        if (tail.active) begin
            rgb_d = tail.ext ? ext_rgb : tail.rgb;
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_q         <= '0;
            v_q         <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            rgb_q       <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign pix_req     = active;
    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign frame_start = at_origin;
    assign frame_cnt   = frame_cnt_q;
    assign vpg_de      = de_q;
    assign vpg_hs      = hs_q;
    assign vpg_vs      = vs_q;
    assign vpg_r       = rgb_q[23:16];
    assign vpg_g       = rgb_q[15:8];
    assign vpg_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vpg_timing_pattern.sv
// Directed bench: a reduced-size timing instance (EXT_LAT=2) plus a small positive-sync instance
// (EXT_LAT=0) with its own external pixel source.
module tb_vpg_timing_pattern;

    localparam int HT      = 80;
    localparam int VT      = 38;
    localparam int FRAME   = HT * VT;
    localparam int LAT     = 3;
    localparam int HT_B    = 44;
    localparam int FRAME_B = 968;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [23:0] ext_rgb;
    logic [23:0] ext_s1;
    logic        pix_req, frame_start, vpg_de, vpg_hs, vpg_vs;
    logic [7:0]  pix_x, pix_y, frame_cnt, vpg_r, vpg_g, vpg_b;

    logic        pix_req_b, frame_start_b, de_b, hs_b, vs_b;
    logic [5:0]  pix_x_b, pix_y_b;
    logic [7:0]  frame_cnt_b, r_b, g_b, b_b;
    logic [23:0] ext_rgb_b;

    int n_cmp = 0;
    int n_bad = 0;

    int          xs      [11] = '{0, 7, 8, 16, 24, 32, 40, 48, 55, 56, 63};
    logic [23:0] exp_bar [11] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h0000FF, 24'h000000,
                                  24'h000000};

    // External source for the main instance: data for a request appears two cycles later.
    always @(posedge clk) begin
        ext_s1  <= {pix_x, pix_y, 8'h5A};
        ext_rgb <= ext_s1;
    end

    assign ext_rgb_b = {2'b00, pix_x_b, 2'b00, pix_y_b, 8'hA5};

    vpg_timing_pattern #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .EXT_LAT(2), .XW(8), .YW(8), .CHK_LOG2(3)
    ) dut (
        .clk_25(clk), .reset_n(reset_n), .mode(mode), .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs),
        .vpg_r(vpg_r), .vpg_g(vpg_g), .vpg_b(vpg_b)
    );

    vpg_timing_pattern #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .EXT_LAT(0), .XW(6), .YW(6), .CHK_LOG2(2)
    ) dut_b (
        .clk_25(clk), .reset_n(reset_n), .mode(2'd3), .solid_rgb(24'h000000),
        .ext_rgb(ext_rgb_b), .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b), .vpg_de(de_b), .vpg_hs(hs_b),
        .vpg_vs(vs_b), .vpg_r(r_b), .vpg_g(g_b), .vpg_b(b_b)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync_a();
        int t = 0;
        while (frame_start !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_a: frame_start=%b required 1 within %0d cycles", frame_start, 2 * FRAME);
        end
    endtask

    task automatic sync_b();
        int t = 0;
        while (frame_start_b !== 1'b1 && t < 2 * FRAME_B) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (frame_start_b !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_b: frame_start=%b required 1 within %0d cycles", frame_start_b, 2 * FRAME_B);
        end
    endtask

    task automatic test_reset();
        mode      = 2'd1;
        solid_rgb = 24'h000000;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vpg_de !== 1'b0) begin n_bad++; $display("FAIL rst_de: got %b want 0", vpg_de); end
        n_cmp++; if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin n_bad++; $display("FAIL rst_rgb: got %h want 000000", {vpg_r, vpg_g, vpg_b}); end
        n_cmp++; if (vpg_hs !== 1'b1 || vpg_vs !== 1'b1) begin n_bad++; $display("FAIL rst_sync: hs=%b vs=%b want 1 1", vpg_hs, vpg_vs); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (hs_b !== 1'b0 || vs_b !== 1'b0 || de_b !== 1'b0) begin n_bad++; $display("FAIL rst_b: hs=%b vs=%b de=%b want 0 0 0", hs_b, vs_b, de_b); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (frame_start !== 1'b1 || pix_req !== 1'b1) begin n_bad++; $display("FAIL rel_origin: fs=%b req=%b want 1 1", frame_start, pix_req); end
        n_cmp++; if (pix_x !== 8'd0 || pix_y !== 8'd0) begin n_bad++; $display("FAIL rel_xy: x=%0d y=%0d want 0 0", pix_x, pix_y); end
        @(negedge clk);
        n_cmp++; if (pix_x !== 8'd1 || frame_start !== 1'b0) begin n_bad++; $display("FAIL rel_step: x=%0d fs=%b want 1 0", pix_x, frame_start); end
    endtask

    task automatic test_timing();
        int hs_first = -1, hs_second = -1, vs_first = -1;
        int hs_lo = 0, vs_lo = 0, de_n = 0, de_line0 = 0, de_rise = 0, blank_bad = 0;
        logic prev_hs = 1'b1, prev_de = 1'b0;
        logic [7:0] f0;
        mode = 2'd1;
        sync_a();
        f0 = frame_cnt;
        n_cmp++; if (f0 !== 8'd1) begin n_bad++; $display("FAIL fcnt_first: got %0d want 1", f0); end
        for (int k = 0; k < FRAME; k++) begin
            if (vpg_hs === 1'b0) hs_lo++;
            if (prev_hs === 1'b1 && vpg_hs === 1'b0) begin
                if (hs_first < 0) hs_first = k;
                else if (hs_second < 0) hs_second = k;
            end
            if (vpg_vs === 1'b0) begin
                vs_lo++;
                if (vs_first < 0) vs_first = k;
            end
            if (vpg_de === 1'b1) begin
                de_n++;
                if (k >= LAT && k < LAT + HT) de_line0++;
                if (prev_de !== 1'b1) de_rise++;
            end else if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin
                blank_bad++;
            end
            prev_hs = vpg_hs;
            prev_de = vpg_de;
            @(negedge clk);
        end
        n_cmp++; if (hs_first != 71) begin n_bad++; $display("FAIL hs_start: got k=%0d want 71", hs_first); end
        n_cmp++; if (hs_second - hs_first != HT) begin n_bad++; $display("FAIL hs_period: got %0d want %0d", hs_second - hs_first, HT); end
        n_cmp++; if (hs_lo != 8 * VT) begin n_bad++; $display("FAIL hs_width: got %0d want %0d", hs_lo, 8 * VT); end
        n_cmp++; if (vs_first != 2723) begin n_bad++; $display("FAIL vs_start: got k=%0d want 2723", vs_first); end
        n_cmp++; if (vs_lo != 2 * HT) begin n_bad++; $display("FAIL vs_width: got %0d want %0d", vs_lo, 2 * HT); end
        n_cmp++; if (de_n != 64 * 32) begin n_bad++; $display("FAIL de_total: got %0d want 2048", de_n); end
        n_cmp++; if (de_line0 != 64) begin n_bad++; $display("FAIL de_line: got %0d want 64", de_line0); end
        n_cmp++; if (de_rise != 32) begin n_bad++; $display("FAIL de_lines: got %0d want 32", de_rise); end
        n_cmp++; if (blank_bad != 0) begin n_bad++; $display("FAIL blank_bars: got %0d nonzero blank pixels want 0", blank_bad); end
        n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL frame_len: fs=%b at %0d want 1", frame_start, FRAME); end
        n_cmp++; if (frame_cnt !== f0 + 8'd1) begin n_bad++; $display("FAIL fcnt_inc: got %0d want %0d", frame_cnt, f0 + 8'd1); end
    endtask

    task automatic test_bars();
        mode = 2'd1;
        sync_a();
        for (int k = 0; k < FRAME; k++) begin
            for (int j = 0; j < 11; j++) begin
                if (k == 5 * HT + xs[j] + LAT || k == 31 * HT + xs[j] + LAT) begin
                    n_cmp++;
                    if ({vpg_r, vpg_g, vpg_b} !== exp_bar[j] || vpg_de !== 1'b1) begin
                        n_bad++;
                        $display("FAIL bars x=%0d k=%0d: rgb=%h de=%b want rgb=%h de=1",
                                 xs[j], k, {vpg_r, vpg_g, vpg_b}, vpg_de, exp_bar[j]);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ext();
        int edge_bad = 0, blank_bad = 0;
        mode = 2'd3;
        sync_a();
        for (int k = 0; k < FRAME; k++) begin
            if (k == 3 * HT + 10 + LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'h0A035A || vpg_de !== 1'b1) begin
                    n_bad++; $display("FAIL ext_10_3: rgb=%h de=%b want 0a035a 1", {vpg_r, vpg_g, vpg_b}, vpg_de);
                end
            end
            if (k == LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'h00005A) begin
                    n_bad++; $display("FAIL ext_0_0: rgb=%h want 00005a", {vpg_r, vpg_g, vpg_b});
                end
            end
            if (k == 31 * HT + 63 + LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'h3F1F5A) begin
                    n_bad++; $display("FAIL ext_63_31: rgb=%h want 3f1f5a", {vpg_r, vpg_g, vpg_b});
                end
            end
            if (k < 32 * HT && (k % HT) == LAT && vpg_de !== 1'b1) edge_bad++;
            if (k < 32 * HT && (k % HT) == LAT - 1 && vpg_de !== 1'b0) edge_bad++;
            if (vpg_de !== 1'b1 && {vpg_r, vpg_g, vpg_b} !== 24'h0) blank_bad++;
            @(negedge clk);
        end
        n_cmp++; if (edge_bad != 0) begin n_bad++; $display("FAIL ext_de_rise: got %0d misplaced DE edges want 0", edge_bad); end
        n_cmp++; if (blank_bad != 0) begin n_bad++; $display("FAIL ext_blank: got %0d nonzero blank pixels want 0", blank_bad); end
    endtask

    task automatic test_mode_switch();
        mode      = 2'd0;
        solid_rgb = 24'h123456;
        sync_a();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 10 * HT) begin
                mode      = 2'd2;
                solid_rgb = 24'hABCDEF;
            end
            if (k == 5 * HT + 20 + LAT || k == 20 * HT + 5 + LAT || k == 31 * HT + 63 + LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'h123456) begin
                    n_bad++; $display("FAIL solid_hold k=%0d: rgb=%h want 123456", k, {vpg_r, vpg_g, vpg_b});
                end
            end
            if (k == FRAME + LAT || k == FRAME + 7 + LAT || k == FRAME + 8 * HT + 8 + LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'h000000) begin
                    n_bad++; $display("FAIL chk_black k=%0d: rgb=%h want 000000", k, {vpg_r, vpg_g, vpg_b});
                end
            end
            if (k == FRAME + 8 + LAT || k == FRAME + 8 * HT + LAT || k == FRAME + 30 * HT + 20 + LAT) begin
                n_cmp++;
                if ({vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin
                    n_bad++; $display("FAIL chk_white k=%0d: rgb=%h want ffffff", k, {vpg_r, vpg_g, vpg_b});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        sync_a();
        repeat (20 * HT + 30) @(negedge clk);
        n_cmp++;
        if (vpg_de !== 1'b1 || {vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin
            n_bad++; $display("FAIL pre_reset: de=%b rgb=%h want 1 ffffff", vpg_de, {vpg_r, vpg_g, vpg_b});
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (vpg_de !== 1'b0 || vpg_hs !== 1'b1 || vpg_vs !== 1'b1 || {vpg_r, vpg_g, vpg_b} !== 24'h0) begin
            n_bad++; $display("FAIL mid_reset: de=%b hs=%b vs=%b rgb=%h want 0 1 1 000000",
                              vpg_de, vpg_hs, vpg_vs, {vpg_r, vpg_g, vpg_b});
        end
        n_cmp++; if (frame_cnt !== 8'd0 || pix_x !== 8'd0) begin n_bad++; $display("FAIL mid_reset_cnt: fcnt=%0d x=%0d want 0 0", frame_cnt, pix_x); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL rel_fs: got %b want 1", frame_start); end
        @(negedge clk);
        n_cmp++;
        if (pix_x !== 8'd1 || frame_cnt !== 8'd0 || vpg_de !== 1'b0) begin
            n_bad++; $display("FAIL rel_after: x=%0d fcnt=%0d de=%b want 1 0 0", pix_x, frame_cnt, vpg_de);
        end
    endtask

    task automatic test_small();
        int hs_first = -1, hs_second = -1, vs_first = -1, hs_hi = 0, vs_hi = 0, de_n = 0;
        logic prev_hs = 1'b0;
        sync_b();
        for (int k = 0; k < FRAME_B; k++) begin
            if (hs_b === 1'b1) hs_hi++;
            if (prev_hs === 1'b0 && hs_b === 1'b1) begin
                if (hs_first < 0) hs_first = k;
                else if (hs_second < 0) hs_second = k;
            end
            if (vs_b === 1'b1) begin
                vs_hi++;
                if (vs_first < 0) vs_first = k;
            end
            if (de_b === 1'b1) de_n++;
            if (k == 2 * HT_B + 5 + 1) begin
                n_cmp++;
                if ({r_b, g_b, b_b} !== 24'h0502A5) begin n_bad++; $display("FAIL b_ext_5_2: rgb=%h want 0502a5", {r_b, g_b, b_b}); end
            end
            if (k == 15 * HT_B + 31 + 1) begin
                n_cmp++;
                if ({r_b, g_b, b_b} !== 24'h1F0FA5) begin n_bad++; $display("FAIL b_ext_31_15: rgb=%h want 1f0fa5", {r_b, g_b, b_b}); end
            end
            prev_hs = hs_b;
            @(negedge clk);
        end
        n_cmp++; if (hs_first != 37) begin n_bad++; $display("FAIL b_hs_start: got k=%0d want 37", hs_first); end
        n_cmp++; if (hs_second - hs_first != HT_B) begin n_bad++; $display("FAIL b_line: got %0d want 44", hs_second - hs_first); end
        n_cmp++; if (hs_hi != 4 * 22) begin n_bad++; $display("FAIL b_hs_width: got %0d want 88", hs_hi); end
        n_cmp++; if (vs_first != 18 * HT_B + 1) begin n_bad++; $display("FAIL b_vs_start: got k=%0d want 793", vs_first); end
        n_cmp++; if (vs_hi != 2 * HT_B) begin n_bad++; $display("FAIL b_vs_width: got %0d want 88", vs_hi); end
        n_cmp++; if (de_n != 32 * 16) begin n_bad++; $display("FAIL b_de_total: got %0d want 512", de_n); end
        n_cmp++; if (frame_start_b !== 1'b1) begin n_bad++; $display("FAIL b_frame_len: fs=%b at 968 want 1", frame_start_b); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_ext();
        test_mode_switch();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
